// File: rtl/add_mul_result_buffer.sv
// Result buffer behind the fixed-latency add_mul pipeline: valid tracking, FIFO capture and
// credit-based admission. Define ADD_MUL_RESULT_BUFFER_STATS_EN to add hwm/stall_cycles outputs.
module add_mul_result_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pipe_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
  ,
  output logic [CntW-1:0]   hwm,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SumW = $clog2(DEPTH + LATENCY + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

  if (LATENCY == 0) begin : g_bad_latency
    $error("add_mul_result_buffer: LATENCY must be >= 1");
  end
  if (DEPTH == 0) begin : g_bad_depth
    $error("add_mul_result_buffer: DEPTH must be >= 1");
  end

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic            acc;
  logic            cap;
  logic            pop;
  logic [SumW-1:0] inflight;
  logic [SumW-1:0] credit_sum;

  // Credit covers both FIFO entries and results still inside add_mul; registered state only,
  // so a pop returns its credit one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LATENCY); i++) begin
      inflight = inflight + SumW'(vld_sr_q[i]);
    end
    credit_sum = SumW'(count_q) + inflight;
  end

  assign in_ready  = credit_sum < SumW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_ptr_q];

  assign acc = in_valid & in_ready;
  assign cap = vld_sr_q[LATENCY-1];
  assign pop = out_valid & out_ready;

  always_comb begin
    vld_sr_d    = '0;
    vld_sr_d[0] = acc;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (cap) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case ({cap, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_ptr_q] <= pipe_out;
    end
  end

`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
  logic [CntW-1:0] hwm_q;
  logic [31:0]     stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > hwm_q) begin
        hwm_q <= count_d;
      end
      if (in_valid && !in_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign hwm          = hwm_q;
  assign stall_cycles = stall_q;
`endif

  // The credit rule must make a capture into a full FIFO impossible.
  cap_not_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    cap |-> (count_q < CntW'(DEPTH)));

endmodule

// File: tb/tb_add_mul_result_buffer.sv
// Directed bench for add_mul_result_buffer with a behavioural add_mul model in front of it.
module tb_add_mul_result_buffer;

  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 3;
  localparam int unsigned DEP  = 4;
  localparam int unsigned DEP3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] x, y, z, pipe_out, out_data;
  logic          in_valid3, in_ready3, out_valid3, out_ready3;
  logic [DW-1:0] x3, y3, z3, pipe_out3, out_data3;
`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
  logic [2:0]    hwm, hwm3;
  logic [31:0]   stall_cycles, stall_cycles3;
`endif

  // add_mul model: (x+y)*z, LAT register stages, no reset, no stall
  logic [DW-1:0] pa [LAT];
  logic [DW-1:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= (x + y) * z;
    pb[0] <= (x3 + y3) * z3;
    for (int i = 1; i < int'(LAT); i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign pipe_out  = pa[LAT-1];
  assign pipe_out3 = pb[LAT-1];

  add_mul_result_buffer #(.DATA_W(DW), .LATENCY(LAT), .DEPTH(DEP)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pipe_out     (pipe_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
    ,
    .hwm          (hwm),
    .stall_cycles (stall_cycles)
`endif
  );

  add_mul_result_buffer #(.DATA_W(DW), .LATENCY(LAT), .DEPTH(DEP3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid3),
    .in_ready     (in_ready3),
    .pipe_out     (pipe_out3),
    .out_valid    (out_valid3),
    .out_data     (out_data3),
    .out_ready    (out_ready3)
`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
    ,
    .hwm          (hwm3),
    .stall_cycles (stall_cycles3)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp3_q[$];
  int sent, rcvd, lat, acc_n, stalls, seen;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; z = '0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; x3 = '0; y3 = '0; z3 = '0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid3", 32'(out_valid3), 32'd0);
    check("rst_in_ready3", 32'(in_ready3), 32'd1);
    rst_n = 1'b1;
    step();

    // Single op: (2+3)*4 = 20, visible LAT edges after the accept edge
    x = 2; y = 3; z = 4; in_valid = 1'b1; out_ready = 1'b1;
    check("single_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("single_lat", lat, LAT);
    check("single_data", out_data, 32'd20);
    step();
    check("single_popped", 32'(out_valid), 32'd0);

    // Streaming: 16 ops, x=i, y=i+1, z=3 -> (2i+1)*3, in order
    sent = 0; rcvd = 0;
    for (int c = 0; c < 300 && rcvd < 16; c++) begin
      in_valid = (sent < 16);
      x = sent; y = sent + 1; z = 3;
      if (in_valid && in_ready) begin
        exp_q.push_back((2 * sent + 1) * 3);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_spurious", 32'(out_valid), 32'd0);
        else check("stream_data", out_data, exp_q.pop_front());
        rcvd++;
      end
      step();
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 16);
    check("stream_rcvd", rcvd, 16);

    // Backpressure: fresh reset so the statistics start from zero
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1;
    acc_n = 0; stalls = 0;
    for (int c = 0; c < 12; c++) begin
      x = 10 + acc_n; y = 0; z = 1;
      if (in_ready) acc_n++;
      else stalls++;
      step();
    end
    check("bp_accepts", acc_n, 4);
    check("bp_stalls", stalls, 8);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head", out_data, 32'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      check("bp_pop_valid", 32'(out_valid), 32'd1);
      check("bp_pop_data", out_data, 32'(10 + k));
      step();
    end
    check("bp_drained", 32'(out_valid), 32'd0);
`ifdef ADD_MUL_RESULT_BUFFER_STATS_EN
    check("stats_hwm", 32'(hwm), 32'd4);
    check("stats_stalls", stall_cycles, 32'd8);
`endif

    // Reset with 2 results in the FIFO and 2 still in the pipeline
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; x = 20 + k; y = 0; z = 1;
      step();
    end
    in_valid = 1'b0;
    step();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    check("mid_pre_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      if (out_valid) seen++;
      step();
    end
    check("mid_no_stale", seen, 0);
    x = 1; y = 1; z = 7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("mid_fresh_lat", lat, LAT);
    check("mid_fresh_data", out_data, 32'd14);

    // Wrap with DEPTH=3: 10 ops x=i, y=1, z=2 -> (i+1)*2, out_ready toggling
    sent = 0; rcvd = 0;
    for (int c = 0; c < 300 && rcvd < 10; c++) begin
      in_valid3 = (sent < 10);
      out_ready3 = (c % 2 == 0);
      x3 = sent; y3 = 1; z3 = 2;
      if (in_valid3 && in_ready3) begin
        exp3_q.push_back((sent + 1) * 2);
        sent++;
      end
      if (out_valid3 && out_ready3) begin
        if (exp3_q.size() == 0) check("wrap_spurious", 32'(out_valid3), 32'd0);
        else check("wrap_data", out_data3, exp3_q.pop_front());
        rcvd++;
      end
      step();
    end
    in_valid3 = 1'b0;
    check("wrap_rcvd", rcvd, 10);
    check("wrap_empty", 32'(out_valid3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
